corona_scan_sched: RTL and testbench

- Round-robin scheduler that shares one "CORONA" keyword-match engine between NREQ independent 7-bit ASCII character streams.
- Each stream's match progress is saved in a per-requester context, so a word split across several grants is still detected.
- Produces tagged hit pulses and a per-requester saturating hit count.
- Sits between character sources (UART/buffer front-ends) and status/interrupt logic.

---
 rtl/corona_scan_sched.sv | 144 ++++++++++++++
 tb/tb_corona_scan_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corona_scan_sched.sv
`default_nettype none
// corona_scan_sched: round-robin sharing of one "CORONA" matcher across NREQ
// character streams, with per-requester match context and saturating hit counters.
module corona_scan_sched #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAXBURST = 8,
  parameter int CNTW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_char,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              hit_valid,
  output logic [IDW-1:0]    hit_id,
  input  logic [IDW-1:0]    cnt_sel,
  output logic [CNTW-1:0]   cnt_out,
  output logic              busy
);

  localparam int SW = IDW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gid;
  logic [7:0]      burst;
  logic [2:0]      ctx     [NREQ];
  logic [CNTW-1:0] counter [NREQ];

  function automatic logic [6:0] pat_char(input logic [2:0] p);
    case (p)
      3'd0:    pat_char = 7'h43;
      3'd1:    pat_char = 7'h4F;
      3'd2:    pat_char = 7'h52;
      3'd3:    pat_char = 7'h4F;
      3'd4:    pat_char = 7'h4E;
      default: pat_char = 7'h41;
    endcase
  endfunction

  // Rotating priority search: scan downward so the lowest offset from rr_ptr wins.
  logic           sel_found;
  logic [IDW-1:0] sel_idx;
  logic [SW-1:0]  sum;
  logic [IDW-1:0] cand;
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      cand = sum[IDW-1:0];
      if (req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  logic [6:0] ch;
  logic [2:0] p;
  logic [2:0] p_next;
  logic       hit;
  logic       xfer;
  logic       rel_now;
  always_comb begin
    ch     = req_char[7*gid +: 7];
    p      = ctx[gid];
    hit    = 1'b0;
    p_next = '0;
    xfer   = (state == BUSY) && req_valid[gid];
    if (ch == pat_char(p)) begin
      if (p == 3'd5) hit = 1'b1;
      else           p_next = p + 3'd1;
    end else begin
      p_next = (ch == 7'h43) ? 3'd1 : 3'd0;
    end
    rel_now = (state == BUSY) &&
              (!req_valid[gid] || req_last[gid] || (burst == 8'(MAXBURST - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      gid       <= '0;
      burst     <= '0;
      hit_valid <= 1'b0;
      hit_id    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        ctx[i]     <= '0;
        counter[i] <= '0;
      end
    end else begin
      hit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant <= NREQ'(1) << sel_idx;
            gid   <= sel_idx;
            burst <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            ctx[gid] <= req_last[gid] ? 3'd0 : p_next;
            burst    <= burst + 8'd1;
            if (hit) begin
              hit_valid <= 1'b1;
              hit_id    <= gid;
              if (counter[gid] != {CNTW{1'b1}}) counter[gid] <= counter[gid] + CNTW'(1);
            end
          end
          if (rel_now) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign cnt_out   = counter[cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_corona_scan_sched.sv
`default_nettype none
// tb_corona_scan_sched: scoreboard bench for corona_scan_sched in three builds
// (default, MAXBURST=3, CNTW=2) sharing one stimulus bus.
module tb_corona_scan_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [7*NREQ-1:0] req_char  = '0;
  logic [IDW-1:0]    cnt_sel   = '0;

  always #5 clk = ~clk;

  logic [NREQ-1:0] rdy_a, gnt_a, rdy_b, gnt_b, rdy_c, gnt_c;
  logic            hv_a, hv_b, hv_c, busy_a, busy_b, busy_c;
  logic [IDW-1:0]  hid_a, hid_b, hid_c;
  logic [7:0]      cnt_a, cnt_b;
  logic [1:0]      cnt_c;

  corona_scan_sched #(.NREQ(4), .IDW(2), .MAXBURST(8), .CNTW(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_char(req_char), .req_last(req_last),
    .req_ready(rdy_a), .grant(gnt_a), .hit_valid(hv_a), .hit_id(hid_a),
    .cnt_sel(cnt_sel), .cnt_out(cnt_a), .busy(busy_a));
  corona_scan_sched #(.NREQ(4), .IDW(2), .MAXBURST(3), .CNTW(8)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_char(req_char), .req_last(req_last),
    .req_ready(rdy_b), .grant(gnt_b), .hit_valid(hv_b), .hit_id(hid_b),
    .cnt_sel(cnt_sel), .cnt_out(cnt_b), .busy(busy_b));
  corona_scan_sched #(.NREQ(4), .IDW(2), .MAXBURST(8), .CNTW(2)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_char(req_char), .req_last(req_last),
    .req_ready(rdy_c), .grant(gnt_c), .hit_valid(hv_c), .hit_id(hid_c),
    .cnt_sel(cnt_sel), .cnt_out(cnt_c), .busy(busy_c));

  // Target build whose handshake and outputs the current test follows.
  int tgt = 0;
  logic [NREQ-1:0] rdy_t, gnt_t;
  logic            hv_t, busy_t;
  logic [IDW-1:0]  hid_t;
  logic [7:0]      cnt_t;
  always_comb begin
    rdy_t = rdy_a; gnt_t = gnt_a; hv_t = hv_a; busy_t = busy_a; hid_t = hid_a; cnt_t = cnt_a;
    if (tgt == 1) begin
      rdy_t = rdy_b; gnt_t = gnt_b; hv_t = hv_b; busy_t = busy_b; hid_t = hid_b; cnt_t = cnt_b;
    end else if (tgt == 2) begin
      rdy_t = rdy_c; gnt_t = gnt_c; hv_t = hv_c; busy_t = busy_c; hid_t = hid_c; cnt_t = {6'b0, cnt_c};
    end
  end

  int total = 0;
  int bad = 0;
  int hit_count = 0;
  int exp_id;
  int exp_q[$];
  int grant_log[$];
  int hit_log[$];
  logic [2:0] mctx [NREQ];
  logic [NREQ-1:0] prev_gnt = '0;

  function automatic logic [6:0] pchar(input logic [2:0] p);
    case (p)
      3'd0: return 7'h43;
      3'd1: return 7'h4F;
      3'd2: return 7'h52;
      3'd3: return 7'h4F;
      3'd4: return 7'h4E;
      default: return 7'h41;
    endcase
  endfunction

  function automatic bit is_hit(input logic [2:0] p, input logic [6:0] c);
    return (p == 3'd5) && (c == 7'h41);
  endfunction

  function automatic logic [2:0] next_ctx(input logic [2:0] p, input logic [6:0] c, input logic last);
    if (last) return 3'd0;
    if (c == pchar(p)) return (p == 3'd5) ? 3'd0 : p + 3'd1;
    return (c == 7'h43) ? 3'd1 : 3'd0;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference matcher: steps a private context on every observed transfer.
  initial begin
    for (int i = 0; i < NREQ; i++) mctx[i] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NREQ; i++) mctx[i] = '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && rdy_t[i]) begin
            if (is_hit(mctx[i], req_char[7*i +: 7])) exp_q.push_back(i);
            mctx[i] = next_ctx(mctx[i], req_char[7*i +: 7], req_last[i]);
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on each hit and logs grant starts.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (hv_t === 1'b1) begin
        hit_count++;
        hit_log.push_back(int'(hid_t));
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL hit_unexpected: got hit id %0d, required no hit", hid_t);
        end else begin
          exp_id = exp_q.pop_front();
          if (hid_t !== IDW'(exp_id)) begin
            bad++;
            $display("FAIL hit_id: got %0d, required %0d", hid_t, exp_id);
          end
        end
      end
      if (gnt_t !== '0 && prev_gnt === '0) grant_log.push_back(oh_idx(gnt_t));
      if (gnt_t !== '0 && prev_gnt !== '0 && gnt_t !== prev_gnt) begin
        total++; bad++;
        $display("FAIL grant_gap: grant went %b -> %b, required an idle cycle", prev_gnt, gnt_t);
      end
    end
    prev_gnt = gnt_t;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); grant_log.delete(); hit_log.delete(); hit_count = 0;
  endtask

  // Present one character; returns at the negedge after it was accepted.
  task automatic put(input int r, input logic [6:0] c, input bit last);
    int n;
    n = 0;
    req_valid[r] = 1'b1; req_char[7*r +: 7] = c; req_last[r] = last;
    while (rdy_t[r] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL put_timeout: req %0d char %h ready=%b, required 1", r, c, rdy_t[r]);
    end else @(negedge clk);
  endtask

  task automatic send(input int r, input string s, input bit last_on_end);
    for (int i = 0; i < s.len(); i++) put(r, 7'(s[i]), last_on_end && (i == s.len() - 1));
    req_valid[r] = 1'b0; req_last[r] = 1'b0;
  endtask

  task automatic test_reset();
    tgt = 0;
    do_reset();
    total++; if (gnt_a !== '0 || rdy_a !== '0) begin bad++; $display("FAIL reset_grant: grant=%b ready=%b, required 0", gnt_a, rdy_a); end
    total++; if (busy_a !== 1'b0 || hv_a !== 1'b0 || hid_a !== '0) begin bad++; $display("FAIL reset_flags: busy=%b hit=%b id=%0d, required 0", busy_a, hv_a, hid_a); end
    total++; if (gnt_b !== '0 || gnt_c !== '0) begin bad++; $display("FAIL reset_grant_bc: %b %b, required 0", gnt_b, gnt_c); end
    for (int s = 0; s < NREQ; s++) begin
      cnt_sel = IDW'(s); #1;
      total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_cnt%0d: got %0d, required 0", s, cnt_a); end
    end
  endtask

  task automatic test_single();
    tgt = 0;
    do_reset();
    cnt_sel = 2'd0;
    put(0, 7'h43, 1'b0);
    total++; if (busy_t !== 1'b1 || gnt_t !== 4'b0001) begin bad++; $display("FAIL single_busy: busy=%b grant=%b, required 1/0001", busy_t, gnt_t); end
    put(0, 7'h4F, 1'b0); put(0, 7'h52, 1'b0); put(0, 7'h4F, 1'b0); put(0, 7'h4E, 1'b0);
    put(0, 7'h41, 1'b1);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    total++; if (hv_t !== 1'b1 || hid_t !== 2'd0) begin bad++; $display("FAIL single_hit: hit=%b id=%0d, required 1/0", hv_t, hid_t); end
    total++; if (gnt_t !== '0) begin bad++; $display("FAIL single_release: grant=%b, required 0", gnt_t); end
    total++; if (cnt_t !== 8'd1) begin bad++; $display("FAIL single_cnt: got %0d, required 1", cnt_t); end
    repeat (3) @(negedge clk);
    total++; if (hv_t !== 1'b0 || hit_count !== 1) begin bad++; $display("FAIL single_pulse: hit=%b count=%0d, required 0/1", hv_t, hit_count); end
  endtask

  task automatic test_split();
    int eg[4] = '{0, 1, 0, 1};
    tgt = 1;
    do_reset();
    fork
      send(0, "CORONA", 1'b0);
      send(1, "CORONA", 1'b0);
    join
    repeat (4) @(negedge clk);
    total++;
    if (grant_log.size() != 4) begin bad++; $display("FAIL split_grants: got %0d grants, required 4", grant_log.size()); end
    else for (int i = 0; i < 4; i++) if (grant_log[i] != eg[i]) begin
      bad++; $display("FAIL split_order: grant %0d to req %0d, required %0d", i, grant_log[i], eg[i]); break;
    end
    total++;
    if (hit_log.size() != 2 || hit_log[0] != 0 || hit_log[1] != 1) begin
      bad++; $display("FAIL split_hits: got %0d hits, required 2 (id 0 then 1)", hit_log.size());
    end
    for (int s = 0; s < 2; s++) begin
      cnt_sel = IDW'(s); #1;
      total++; if (cnt_t !== 8'd1) begin bad++; $display("FAIL split_cnt%0d: got %0d, required 1", s, cnt_t); end
    end
  endtask

  task automatic test_restart();
    tgt = 0;
    do_reset();
    send(2, "CORCORONA", 1'b1); repeat (3) @(negedge clk);
    total++; if (hit_count !== 1) begin bad++; $display("FAIL restart_corcorona: hits=%0d, required 1", hit_count); end
    send(2, "COROXA", 1'b1); repeat (3) @(negedge clk);
    total++; if (hit_count !== 1) begin bad++; $display("FAIL restart_coroxa: hits=%0d, required 1", hit_count); end
    send(2, "CORONACORONA", 1'b1); repeat (3) @(negedge clk);
    total++; if (hit_count !== 3) begin bad++; $display("FAIL restart_double: hits=%0d, required 3", hit_count); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL restart_pending: %0d expected hits unseen, required 0", exp_q.size()); end
  endtask

  task automatic test_last_cancel();
    tgt = 0;
    do_reset();
    send(1, "COR", 1'b1);
    total++; if (dut_a.ctx[1] !== 3'd0) begin bad++; $display("FAIL last_ctx: ctx[1]=%0d, required 0", dut_a.ctx[1]); end
    send(1, "ONA", 1'b1); repeat (3) @(negedge clk);
    total++; if (hit_count !== 0) begin bad++; $display("FAIL last_nohit: hits=%0d, required 0", hit_count); end
  endtask

  task automatic test_round_robin();
    int n;
    tgt = 0;
    do_reset();
    req_char = {4{7'h58}}; req_valid = 4'hF;
    repeat (50) @(negedge clk);
    req_valid = '0;
    total++;
    if (grant_log.size() < 5 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2 ||
        grant_log[3] != 3 || grant_log[4] != 0) begin
      bad++; $display("FAIL rr_order: %0d grants logged, required order 0,1,2,3,0", grant_log.size());
    end
    do_reset();
    req_valid = 4'hF;
    n = 0;
    while (gnt_t !== 4'b0010 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL stall_wait: grant=%b, required 0010", gnt_t); end
    else begin
      repeat (2) @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      total++; if (gnt_t !== '0) begin bad++; $display("FAIL stall_release: grant=%b, required 0", gnt_t); end
      @(negedge clk);
      if (gnt_t !== 4'b0100) begin bad++; $display("FAIL stall_next: grant=%b, required 0100", gnt_t); end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    tgt = 0;
    do_reset();
    cnt_sel = 2'd0;
    send(0, "CORONA", 1'b1); repeat (3) @(negedge clk);
    total++; if (cnt_t !== 8'd1) begin bad++; $display("FAIL rmid_pre: cnt=%0d, required 1", cnt_t); end
    put(0, 7'h43, 1'b0); put(0, 7'h4F, 1'b0); put(0, 7'h52, 1'b0); put(0, 7'h4F, 1'b0);
    req_char[6:0] = 7'h4E;
    rst = 1'b1;
    @(negedge clk);
    total++; if (gnt_t !== '0 || hv_t !== 1'b0 || busy_t !== 1'b0) begin
      bad++; $display("FAIL rmid_state: grant=%b hit=%b busy=%b, required 0", gnt_t, hv_t, busy_t);
    end
    req_valid = '0;
    rst = 1'b0;
    for (int s = 0; s < NREQ; s++) begin
      cnt_sel = IDW'(s); #1;
      total++; if (cnt_t !== 8'd0) begin bad++; $display("FAIL rmid_cnt%0d: got %0d, required 0", s, cnt_t); end
    end
    send(0, "ONA", 1'b1); repeat (3) @(negedge clk);
    total++; if (hit_count !== 1) begin bad++; $display("FAIL rmid_nohit: hits=%0d, required 1", hit_count); end
  endtask

  task automatic test_saturation();
    tgt = 2;
    do_reset();
    cnt_sel = 2'd3;
    for (int i = 1; i <= 5; i++) begin
      send(3, "CORONA", 1'b1);
      repeat (2) @(negedge clk);
      total++;
      if (cnt_t !== 8'((i > 3) ? 3 : i)) begin
        bad++; $display("FAIL sat_cnt_after_%0d: got %0d, required %0d", i, cnt_t, (i > 3) ? 3 : i);
      end
    end
    @(negedge clk);
    total++; if (hit_count !== 5) begin bad++; $display("FAIL sat_hits: hits=%0d, required 5", hit_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_split();
    test_restart();
    test_last_cancel();
    test_round_robin();
    test_reset_mid();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
